token_decim_sched: RTL and testbench

//   Shares one serial token decimator between N_CH requesters.
//   - Each cycle a round-robin arbiter picks one token.
//   - A per-channel programmable ratio K passes only every Kth token of that

---
 rtl/token_sched_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/token_decim_sched.sv | 81 ++++++++
 tb/tb_token_decim_sched.sv | 134 +++++++++++++
 4 files changed

// File: rtl/token_sched_pkg.sv
// token_sched_pkg: shared defaults, channel/ratio types and reset ratio for token_decim_sched.
package token_sched_pkg;
    localparam int N_CH_DEF    = 4;
    localparam int RATIO_W_DEF = 4;
    typedef logic [$clog2(N_CH_DEF)-1:0] ch_t;
    typedef logic [RATIO_W_DEF-1:0]      ratio_t;
    localparam ratio_t RATIO_RST = ratio_t'(2);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with one-hot grant and grant index.
// Ports: clk, rst (async, active-low), en (grants allowed), req[N] in;
//        gnt[N] one-hot combinational grant, idx index of the granted requester.
module rr_arbiter #(
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // scan starts one past the last granted requester
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(ptr_q) + k) % N;
            if (en && req[j] && !found) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
        ptr_d = found ? idx : ptr_q;
    end
    // pointer at N-1 makes requester 0 the first choice after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= IW'(N - 1);
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/token_decim_sched.sv
// token_decim_sched: round-robin shared token decimator passing every Kth token per channel.
// Ports: clk, rst (async, active-low); req[N_CH] in, gnt[N_CH] one-hot combinational out;
//        cfg_we/cfg_ch/cfg_ratio config write; out_valid/out_ch/out_ready output handshake.
module token_decim_sched
    import token_sched_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int RATIO_W = RATIO_W_DEF,
    localparam int CW     = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    req,
    output logic [N_CH-1:0]    gnt,
    input  logic               cfg_we,
    input  logic [CW-1:0]      cfg_ch,
    input  logic [RATIO_W-1:0] cfg_ratio,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    input  logic               out_ready
);
    logic [RATIO_W-1:0] cnt_q [N_CH];
    logic [RATIO_W-1:0] cnt_d [N_CH];
    logic [RATIO_W-1:0] ratio_q [N_CH];
    logic [RATIO_W-1:0] ratio_d [N_CH];
    logic               out_valid_q, out_valid_d;
    logic [CW-1:0]      out_ch_q, out_ch_d;
    logic [CW-1:0]      gnt_idx;
    logic               accept_en, pass;
    assign accept_en = !out_valid_q || out_ready;
    rr_arbiter #(.N(N_CH)) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (accept_en),
        .req (req),
        .gnt (gnt),
        .idx (gnt_idx)
    );
    always_comb begin
        pass = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            ratio_d[i] = ratio_q[i];
            // a config write beats a same-cycle grant: the token is consumed but dropped
            if (cfg_we && int'(cfg_ch) == i) begin
                ratio_d[i] = cfg_ratio;
                cnt_d[i]   = '0;
            end else if (gnt[i] && ratio_q[i] != '0) begin
                // one extra bit so cnt+1 cannot wrap at the largest ratio
                if ((RATIO_W+1)'(cnt_q[i]) + (RATIO_W+1)'(1) == (RATIO_W+1)'(ratio_q[i])) begin
                    cnt_d[i] = '0;
                    pass     = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + RATIO_W'(1);
                end
            end
        end
        // a pass only happens when accept_en, so it never overwrites an unaccepted token
        out_valid_d = pass || (out_valid_q && !out_ready);
        out_ch_d    = pass ? gnt_idx : out_ch_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= '0;
                ratio_q[i] <= RATIO_W'(RATIO_RST);
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                ratio_q[i] <= ratio_d[i];
            end
        end
    end
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_token_decim_sched.sv
// tb_token_decim_sched: scoreboard bench for token_decim_sched with directed vectors.
module tb_token_decim_sched;
    import token_sched_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic       cfg_we = 1'b0;
    ch_t        cfg_ch = '0;
    ratio_t     cfg_ratio = '0;
    logic       out_valid;
    ch_t        out_ch;
    logic       out_ready = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    token_decim_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_ratio (cfg_ratio),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle, check the combinational grant, push the token the grant should pass
    task automatic cyc(input logic [3:0] r, input logic rdy, input logic we, input ch_t ch,
                       input ratio_t k, input logic [3:0] eg, input int pass_ch);
        req = r; out_ready = rdy; cfg_we = we; cfg_ch = ch; cfg_ratio = k;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        if (pass_ch >= 0) exp_q.push_back(pass_ch);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input logic v, input ch_t c);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_ch", 32'(out_ch), 32'(c));
    endtask

    task automatic halve_seq();
        cyc(4'b0001, 1, 0, 0, 0, 4'b0001, -1);
        cyc(4'b0001, 1, 0, 0, 0, 4'b0001, 0);
        cyc(4'b0001, 1, 0, 0, 0, 4'b0001, -1);
        cyc(4'b0001, 1, 0, 0, 0, 4'b0001, 0);
        cyc(4'b0000, 1, 0, 0, 0, 4'b0000, -1);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_tok: got ch %0d, required no token at %0t", out_ch, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("out_tok", 32'(out_ch), 32'(e));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out(0, 0);
        chk("gnt_rst", 32'(gnt), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        // default ratio 2 on ch0
        halve_seq();
        // all ratios 1, round robin continues after last grant (ch0)
        for (int i = 0; i < 4; i++) cyc(4'b0000, 1, 1, ch_t'(i), 1, 4'b0000, -1);
        cyc(4'b1111, 1, 0, 0, 0, 4'b0010, 1);
        cyc(4'b1111, 1, 0, 0, 0, 4'b0100, 2);
        cyc(4'b1111, 1, 0, 0, 0, 4'b1000, 3);
        cyc(4'b1111, 1, 0, 0, 0, 4'b0001, 0);
        cyc(4'b1111, 1, 0, 0, 0, 4'b0010, 1);
        // backpressure holds the register and blocks grants
        cyc(4'b0000, 1, 0, 0, 0, 4'b0000, -1);
        cyc(4'b1111, 0, 0, 0, 0, 4'b0100, 2);
        chk_out(1, 2);
        cyc(4'b1111, 0, 0, 0, 0, 4'b0000, -1);
        chk_out(1, 2);
        cyc(4'b1111, 1, 0, 0, 0, 4'b1000, 3);
        cyc(4'b0000, 1, 0, 0, 0, 4'b0000, -1);
        // ch2 ratio 3, then ratio 0
        cyc(4'b0000, 1, 1, 2, 3, 4'b0000, -1);
        for (int i = 1; i <= 6; i++) cyc(4'b0100, 1, 0, 0, 0, 4'b0100, (i % 3 == 0) ? 2 : -1);
        cyc(4'b0000, 1, 1, 2, 0, 4'b0000, -1);
        for (int i = 0; i < 3; i++) cyc(4'b0100, 1, 0, 0, 0, 4'b0100, -1);
        chk_out(0, 2);
        // config coincident with a ch1 grant clears the count; other-channel config harmless
        cyc(4'b0000, 1, 1, 1, 2, 4'b0000, -1);
        cyc(4'b0010, 1, 0, 0, 0, 4'b0010, -1);
        cyc(4'b0010, 1, 1, 1, 2, 4'b0010, -1);
        cyc(4'b0010, 1, 0, 0, 0, 4'b0010, -1);
        cyc(4'b0010, 1, 1, 3, 1, 4'b0010, 1);
        cyc(4'b0000, 1, 0, 0, 0, 4'b0000, -1);
        // async reset with a pending token, which is discarded
        cyc(4'b0001, 0, 0, 0, 0, 4'b0001, -1);
        chk_out(1, 0);
        req = '0;
        #3;
        rst = 1'b0;
        #1;
        chk_out(0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        halve_seq();
        cyc(4'b0000, 1, 0, 0, 0, 4'b0000, -1);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
